// File: rtl/uart_echo_pkg.sv
// Shared encodings for the UART echo buffer: operating modes, transmit FSM
// states and the control characters used for CR->CRLF expansion.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_ECHO = 2'b01,
        MODE_CRLF = 2'b10
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_SEND,
        ST_HOLD,
        ST_WAIT_DONE
    } state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/uart_echo_buffer_if.sv
// Receive/transmit handshake between uart_rx, uart_tx and the echo buffer.
// The echo buffer is the slave; the surrounding UART pair is the master.
interface uart_echo_buffer_if #(
    parameter int DATA_W = 8
);
    logic              recv_valid;
    logic [DATA_W-1:0] recv_data;
    logic              recv_break;
    logic              tx_busy;
    logic              tx_enable;
    logic [DATA_W-1:0] tx_data;

    modport master (
        output recv_valid, recv_data, recv_break, tx_busy,
        input  tx_enable, tx_data
    );

    modport slave (
        input  recv_valid, recv_data, recv_break, tx_busy,
        output tx_enable, tx_data
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extended pointers (no wasted entry), flush, and
// acceptance of a push into a full FIFO when a pop happens on the same edge.
module uart_sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head_data,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                       (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign level     = wr_ptr - rd_ptr;
    assign head_data = mem[rd_ptr[ADDR_W-1:0]];

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end
endmodule

// File: rtl/uart_echo_buffer.sv
// Buffered rx->tx echo engine: FIFO between uart_rx and uart_tx, hold/echo/
// CRLF modes, BREAK flush and saturating overflow/break statistics.
module uart_echo_buffer
    import uart_echo_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    parameter  int CNT_W  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    uart_echo_buffer_if.slave bus,
    output logic [ADDR_W:0]   fifo_level,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [CNT_W-1:0]  ovf_count,
    output logic [CNT_W-1:0]  break_count,
    output logic [DATA_W-1:0] last_data,
    output logic              echo_active
);
    localparam logic [DATA_W-1:0] CR_CHAR = CHAR_CR[DATA_W-1:0];
    localparam logic [DATA_W-1:0] LF_CHAR = CHAR_LF[DATA_W-1:0];

    state_t            state;
    logic              lf_pending;
    logic              push_req;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;

    assign push_req    = bus.recv_valid && !bus.recv_break;
    assign fifo_pop    = (state == ST_POP) && !bus.recv_break;
    assign echo_active = (state != ST_IDLE);

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .pop       (fifo_pop),
        .flush     (bus.recv_break),
        .push_data (bus.recv_data),
        .head_data (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            bus.tx_enable <= 1'b0;
            bus.tx_data   <= '0;
            lf_pending    <= 1'b0;
        end else begin
            case (state)
                // A frame arriving this edge counts as available so POP follows it directly.
                ST_IDLE: if (mode != MODE_HOLD && !bus.tx_busy && (!fifo_empty || push_req))
                    state <= ST_POP;
                ST_POP: begin
                    if (bus.recv_break) begin
                        state <= ST_IDLE;
                    end else begin
                        bus.tx_data   <= fifo_head;
                        lf_pending    <= (mode == MODE_CRLF) && (fifo_head == CR_CHAR);
                        bus.tx_enable <= 1'b1;
                        state         <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    bus.tx_enable <= 1'b0;
                    state         <= ST_HOLD;
                end
                ST_HOLD: state <= ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        if (lf_pending && !bus.recv_break) begin
                            lf_pending    <= 1'b0;
                            bus.tx_data   <= LF_CHAR;
                            bus.tx_enable <= 1'b1;
                            state         <= ST_SEND;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Later non-blocking write wins: a BREAK cancels any pending LF.
            if (bus.recv_break) lf_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_data   <= '0;
            ovf_count   <= '0;
            break_count <= '0;
        end else begin
            if (bus.recv_valid) last_data <= bus.recv_data;
            if (push_req && fifo_full && !fifo_pop && ovf_count != '1)
                ovf_count <= ovf_count + 1'b1;
            if (bus.recv_break && break_count != '1)
                break_count <= break_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_echo_buffer.sv
// Self-checking bench for uart_echo_buffer: queue-based reference model,
// tx_busy model of the transmitter and a second small-counter instance.
module tb_uart_echo_buffer;
    import uart_echo_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BUSY   = 10;
    localparam int DEPTH2 = 4;
    localparam int CNT_W2 = 2;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic reset2 = 1'b1;
    logic [1:0] mode  = 2'b00;
    logic [1:0] mode2 = 2'b00;

    uart_echo_buffer_if #(.DATA_W(DATA_W)) bus ();
    uart_echo_buffer_if #(.DATA_W(DATA_W)) bus2 ();

    logic [ADDR_W:0]   fifo_level;
    logic              fifo_full, fifo_empty, echo_active;
    logic [CNT_W-1:0]  ovf_count, break_count;
    logic [DATA_W-1:0] last_data;

    logic [$clog2(DEPTH2):0] fifo_level2;
    logic                    fifo_full2, fifo_empty2, echo_active2;
    logic [CNT_W2-1:0]       ovf_count2, break_count2;
    logic [DATA_W-1:0]       last_data2;

    uart_echo_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .mode(mode), .bus(bus),
        .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .ovf_count(ovf_count), .break_count(break_count),
        .last_data(last_data), .echo_active(echo_active)
    );

    uart_echo_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH2), .CNT_W(CNT_W2)) dut2 (
        .clk(clk), .reset(reset2), .mode(mode2), .bus(bus2),
        .fifo_level(fifo_level2), .fifo_full(fifo_full2), .fifo_empty(fifo_empty2),
        .ovf_count(ovf_count2), .break_count(break_count2),
        .last_data(last_data2), .echo_active(echo_active2)
    );

    assign bus2.recv_valid = bus.recv_valid;
    assign bus2.recv_data  = bus.recv_data;
    assign bus2.recv_break = bus.recv_break;
    assign bus2.tx_busy    = 1'b0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmit monitor and a uart_tx stand-in that stays busy BUSY cycles per frame.
    logic [7:0] got_q[$];
    int         got_cyc[$];

    initial forever begin
        @(negedge clk);
        if (bus.tx_enable === 1'b1) begin
            got_q.push_back(bus.tx_data);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_enable === 1'b1) begin
                @(posedge clk); #1 bus.tx_busy = 1'b1;
                repeat (BUSY) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    // Reference model: what the FIFO holds and what must appear on the line.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         m_ovf, m_brk;
    logic [7:0] m_last;

    task automatic model_clear();
        mq.delete(); exp_q.delete(); got_q.delete(); got_cyc.delete();
        m_ovf = 0; m_brk = 0; m_last = 8'h00;
    endtask

    task automatic model_push(input logic [7:0] d);
        m_last = d;
        if (mq.size() < DEPTH) mq.push_back(d);
        else if (m_ovf < 255) m_ovf++;
    endtask

    task automatic model_drain(input logic [1:0] md);
        logic [7:0] b;
        while (mq.size() > 0) begin
            b = mq.pop_front();
            exp_q.push_back(b);
            if (md == MODE_CRLF && b == 8'h0D) exp_q.push_back(8'h0A);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rx(input logic [7:0] d, input bit brk = 1'b0);
        bus.recv_valid = 1'b1;
        bus.recv_data  = d;
        bus.recv_break = brk;
        step();
        bus.recv_valid = 1'b0;
        bus.recv_break = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while ((!fifo_empty || echo_active || bus.tx_busy) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: timeout after %0d cycles, observed busy expected idle", tag, k);
        end
        step(2);
    endtask

    task automatic wait_sent(input string tag, input int count, input int budget);
        int k = 0;
        while (got_q.size() < count && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: timeout, observed %0d frames expected %0d", tag, got_q.size(), count);
        end
    endtask

    task automatic compare_tx(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tx_enable"},   bus.tx_enable, 0);
        check({tag, "_tx_data"},     bus.tx_data, 0);
        check({tag, "_fifo_level"},  fifo_level, 0);
        check({tag, "_fifo_empty"},  fifo_empty, 1);
        check({tag, "_fifo_full"},   fifo_full, 0);
        check({tag, "_ovf_count"},   ovf_count, 0);
        check({tag, "_break_count"}, break_count, 0);
        check({tag, "_last_data"},   last_data, 0);
        check({tag, "_echo_active"}, echo_active, 0);
    endtask

    task automatic do_reset();
        int k = 0;
        while (bus.tx_busy && k < 4 * BUSY) begin step(); k++; end
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        logic [7:0] d;
        bus.recv_valid = 1'b0;
        bus.recv_data  = '0;
        bus.recv_break = 1'b0;
        model_clear();

        step(3);
        check_reset_state("reset");
        reset = 1'b0;
        step();

        // Echo, single frame: two-cycle receive-to-send latency.
        mode = MODE_ECHO;
        step();
        t0 = cyc;
        rx(8'hA5);
        model_push(8'hA5);
        check("single_level_after_push", fifo_level, 1);
        step();
        check("single_tx_enable", bus.tx_enable, 1);
        check("single_tx_data", bus.tx_data, 8'hA5);
        check("single_empty_after_pop", fifo_empty, 1);
        check("single_last_data", last_data, m_last);
        wait_idle("single_idle", 200);
        check("single_latency", got_cyc.size() > 0 ? got_cyc[0] - t0 : -1, 2);
        model_drain(MODE_ECHO);
        compare_tx("single");

        // CR followed by A in CRLF mode, then in plain echo mode.
        mode = MODE_CRLF;
        rx(8'h0D); model_push(8'h0D);
        rx(8'h41); model_push(8'h41);
        wait_idle("crlf_idle", 300);
        check("crlf_gap_lf", got_cyc.size() > 2 ? got_cyc[1] - got_cyc[0] : -1, BUSY + 2);
        check("crlf_gap_next", got_cyc.size() > 2 ? got_cyc[2] - got_cyc[1] : -1, BUSY + 4);
        model_drain(MODE_CRLF);
        compare_tx("crlf");

        mode = MODE_ECHO;
        rx(8'h0D); model_push(8'h0D);
        rx(8'h41); model_push(8'h41);
        wait_idle("echo_cr_idle", 300);
        check("echo_cr_gap", got_cyc.size() > 1 ? got_cyc[1] - got_cyc[0] : -1, BUSY + 4);
        model_drain(MODE_ECHO);
        compare_tx("echo_cr");

        // Random traffic with CRs sprinkled in, CRLF mode.
        mode = MODE_CRLF;
        for (int i = 0; i < 8; i++) begin
            d = (i % 3 == 0) ? 8'h0D : 8'($urandom);
            rx(d);
            model_push(d);
        end
        wait_idle("rand_crlf_idle", 800);
        model_drain(MODE_CRLF);
        compare_tx("rand_crlf");
        check("rand_crlf_last", last_data, m_last);

        // Overflow in hold mode, then a push coinciding with the first POP.
        do_reset();
        mode = MODE_HOLD;
        for (int i = 0; i < DEPTH + 4; i++) begin
            d = 8'($urandom);
            rx(d);
            model_push(d);
        end
        check("ovf_full", fifo_full, 1);
        check("ovf_level", fifo_level, mq.size());
        check("ovf_count", ovf_count, m_ovf);
        check("ovf_no_tx", got_q.size(), 0);
        mode = MODE_ECHO;
        step();
        d = 8'($urandom);
        rx(d);
        exp_q.push_back(mq.pop_front());
        mq.push_back(d);
        m_last = d;
        check("fullpop_level", fifo_level, DEPTH);
        check("fullpop_full", fifo_full, 1);
        check("fullpop_ovf", ovf_count, m_ovf);
        wait_idle("fullpop_idle", 800);
        model_drain(MODE_ECHO);
        compare_tx("fullpop");

        // BREAK with a simultaneous frame while a frame waits on tx_busy.
        do_reset();
        mode = MODE_ECHO;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            rx(d);
            model_push(d);
        end
        wait_sent("brk_first", 1, 100);
        step(3);
        exp_q.push_back(mq.pop_front());
        d = 8'($urandom);
        rx(d, 1'b1);
        mq.delete();
        m_last = d;
        m_brk++;
        check("brk_level", fifo_level, 0);
        check("brk_empty", fifo_empty, 1);
        check("brk_count", break_count, m_brk);
        check("brk_ovf", ovf_count, m_ovf);
        check("brk_last_data", last_data, m_last);
        wait_idle("brk_idle", 200);
        step(20);
        compare_tx("brk");

        // BREAK during a CR frame cancels its pending LF.
        mode = MODE_CRLF;
        rx(8'h0D);
        wait_sent("brk_lf_first", 1, 100);
        step(3);
        bus.recv_break = 1'b1;
        step();
        bus.recv_break = 1'b0;
        m_brk++;
        exp_q.push_back(8'h0D);
        wait_idle("brk_lf_idle", 200);
        step(20);
        compare_tx("brk_lf");
        check("brk_lf_count", break_count, m_brk);

        // Reset asserted while tx_enable is high.
        do_reset();
        mode = MODE_ECHO;
        rx(8'($urandom));
        step();
        check("rst_send_tx_enable", bus.tx_enable, 1);
        reset = 1'b1;
        step();
        check_reset_state("rst_send");
        reset = 1'b0;
        do_reset();

        // Counter saturation: CNT_W=8 instance and CNT_W=2 instance in parallel.
        reset2 = 1'b0;
        mode   = MODE_HOLD;
        for (int i = 0; i < DEPTH + 5; i++) begin
            d = 8'($urandom);
            rx(d);
            model_push(d);
        end
        check("sat_ovf_wide", ovf_count, m_ovf);
        check("sat_full_wide", fifo_full, 1);
        check("sat_ovf_narrow", ovf_count2, (DEPTH + 5 - DEPTH2 > 3) ? 3 : DEPTH + 5 - DEPTH2);
        check("sat_level_narrow", fifo_level2, DEPTH2);
        check("sat_full_narrow", fifo_full2, 1);
        check("sat_last_narrow", last_data2, m_last);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
